seg_frame_arb: RTL
==================

Name: seg_frame_arb

Overview:
- Owns the four 16-bit display words feeding the 16-digit hex seven-segment scanner (data_A..data_D).
- Shares that display between two requesters:
  - the CPU MMIO store port, which writes double-buffered shadow words and commits them;
  - a debug monitor, which requests temporary takeover with a full 64-bit frame.
- Sequences takeover time and a cooldown so neither requester starves.

Parameters:
- HOLD_CYCLES, 50_000_000: cycles a granted debug frame stays on display (>=1).
- COOL_CYCLES, 10_000_000: minimum cycles of CPU frame after a debug hold ends (>=1).
- CNT_W, 32: width of the internal hold/cool counter; must hold max(HOLD_CYCLES, COOL_CYCLES).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  CPU shadow-word write strobe
- wr_addr  in  2  shadow word select: 0=A, 1=B, 2=C, 3=D
- wr_data  in  16  shadow write data
- commit  in  1  copy all shadow words to the CPU active frame
- dbg_req  in  1  debug takeover request (level, held until ack)
- dbg_frame  in  64  debug frame {D,C,B,A}, sampled on ack
- dbg_ack  out  1  one-cycle pulse: request granted and frame latched
- dbg_busy  out  1  high while the debug frame is displayed
- data_A, data_B, data_C, data_D  out  16 each  words to the display scanner (registered)

Behaviour:
- Reset (async, rst=1):
  - shadow[0..3], cpu_act[0..3] and dbg_buf cleared to 0.
  - data_A..D=0, dbg_ack=0, dbg_busy=0, FSM=S_CPU, counter=0.
  - Reset mid-hold or mid-cooldown aborts to S_CPU with zeroed frames.
- Shadow write: wr_en=1 writes shadow[wr_addr]<=wr_data at the clock edge. It never alters the displayed words directly.
- Commit: commit=1 copies cpu_act[i]<=shadow[i] for all i at the edge.
  - If wr_en and commit coincide, the commit copies the updated value, i.e. shadow written this cycle is forwarded.
  - Commits are accepted in every FSM state. During S_DBG the new CPU frame appears when control returns.
- FSM:
  - S_CPU: display cpu_act. If dbg_req=1: latch dbg_buf<=dbg_frame, pulse dbg_ack, load counter=HOLD_CYCLES-1, go to S_DBG.
  - S_DBG: display dbg_buf, dbg_busy=1. Counter decrements each cycle. At counter==0: load counter=COOL_CYCLES-1, go to S_COOL. dbg_req is ignored (no ack) in this state.
  - S_COOL: display cpu_act. Counter decrements. At counter==0 go to S_CPU. A pending dbg_req waits and is granted on the first S_CPU cycle evaluated, i.e. the cycle after S_COOL expiry.
- Output timing:
  - data_A..D are registered and reflect the state/frame selected in the previous cycle, so one cycle of latency from a commit or state change.
  - dbg_ack is registered, high exactly the cycle after the S_CPU grant edge. The bench checks dbg_ack=1 on the first cycle with FSM=S_DBG.
- Hold length: debug display lasts exactly HOLD_CYCLES cycles (dbg_busy high HOLD_CYCLES cycles).
- Cooldown: S_COOL lasts exactly COOL_CYCLES cycles.
- Requester rules: dbg_frame changing after ack has no effect. dbg_req dropping before ack withdraws the request, no ack issued.
- Counter never wraps; it is reloaded on every state entry.

Optional Feature:
- Macro: SEG_FRAME_ARB_READBACK_EN.
- When defined, adds the following ports:
  - rd_addr in 3;
  - rd_data out 16, combinational:
    - rd_addr 0-3 return shadow[rd_addr];
    - rd_addr 4 returns {14'b0, state[1:0]} with S_CPU=0, S_DBG=1, S_COOL=2;
    - rd_addr 5-7 return 0.
- Used by CPU MMIO loads.
- When undefined, the ports are absent and there is no readback logic; all other behaviour is identical.

Decomposition:
- Shared package/header seg_pkg holds:
  - state encodings S_CPU/S_DBG/S_COOL;
  - word index constants SEG_WORD_A..D;
  - default HOLD/COOL cycle constants.
- One natural sub-module: seg_frame_buf (4x16 shadow plus active registers with write/commit forwarding). The FSM and counter stay in the top.

Test Plan (HOLD_CYCLES=4, COOL_CYCLES=3):
1. rst pulse mid-operation -> all outputs 0 asynchronously, FSM=S_CPU.
2. Write A=1234, B=5678, C=9ABC, D=DEF0 (hex), no commit -> data outputs stay 0. Then commit -> next cycle data_A..D=1234/5678/9ABC/DEF0.
3. wr_en(addr 2, data 0xBEEF) with commit in the same cycle -> data_C=BEEF the next cycle.
4. dbg_req with frame 0xAAAA_BBBB_CCCC_DDDD in S_CPU -> dbg_ack single pulse, data_A=DDDD, data_D=AAAA, dbg_busy high 4 cycles, then the CPU frame returns.
5. dbg_req held through the hold and cooldown -> no second ack until 3 cooldown cycles elapse, then the second ack. A commit during S_DBG is visible only after the hold.
6. dbg_req asserted then dropped before grant while in S_COOL -> no ack, FSM returns to S_CPU and stays there.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment frame arbiter: FSM encodings,
// display word indices and default hold/cooldown lengths.
package seg_pkg;

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_DBG  = 2'd1,
        S_COOL = 2'd2
    } seg_state_t;

    localparam int SEG_WORDS  = 4;
    localparam int SEG_WORD_W = 16;

    localparam logic [1:0] SEG_WORD_A = 2'd0;
    localparam logic [1:0] SEG_WORD_B = 2'd1;
    localparam logic [1:0] SEG_WORD_C = 2'd2;
    localparam logic [1:0] SEG_WORD_D = 2'd3;

    localparam int SEG_HOLD_DEFAULT = 50_000_000;
    localparam int SEG_COOL_DEFAULT = 10_000_000;

endpackage

// File: rtl/seg_frame_buf.sv
// Double-buffered CPU display words: shadow registers plus the committed frame.
// Shadow words are exported only when SEG_FRAME_ARB_READBACK_EN is defined.
module seg_frame_buf
    import seg_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [1:0]                            wr_addr,
    input  logic [SEG_WORD_W-1:0]                 wr_data,
    input  logic                                  commit,
`ifdef SEG_FRAME_ARB_READBACK_EN
    output logic [SEG_WORDS-1:0][SEG_WORD_W-1:0]  shadow,
`endif
    output logic [SEG_WORDS-1:0][SEG_WORD_W-1:0]  cpu_act
);

    genvar gi;
    generate
        for (gi = 0; gi < SEG_WORDS; gi++) begin : g_word
            logic                  hit;
            logic [SEG_WORD_W-1:0] shadow_reg;
            logic [SEG_WORD_W-1:0] act_reg;

            assign hit = wr_en && (wr_addr == 2'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_reg <= '0;
                end else if (hit) begin
                    shadow_reg <= wr_data;
                end
            end

            // A write landing in the commit cycle is forwarded into the frame.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    act_reg <= '0;
                end else if (commit) begin
                    act_reg <= hit ? wr_data : shadow_reg;
                end
            end

            assign cpu_act[gi] = act_reg;
`ifdef SEG_FRAME_ARB_READBACK_EN
            assign shadow[gi]  = shadow_reg;
`endif
        end
    endgenerate

endmodule

// File: rtl/seg_frame_arb.sv
// Display arbiter between CPU frame and debug takeover with hold and cooldown.
// Optional CPU readback port enabled by SEG_FRAME_ARB_READBACK_EN.
module seg_frame_arb
    import seg_pkg::*;
#(
    parameter int HOLD_CYCLES = SEG_HOLD_DEFAULT,
    parameter int COOL_CYCLES = SEG_COOL_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        commit,
    input  logic        dbg_req,
    input  logic [63:0] dbg_frame,
    output logic        dbg_ack,
    output logic        dbg_busy,
    output logic [15:0] data_A,
    output logic [15:0] data_B,
    output logic [15:0] data_C,
    output logic [15:0] data_D
`ifdef SEG_FRAME_ARB_READBACK_EN
    ,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data
`endif
);

    seg_state_t                            state_reg, state_next;
    logic [CNT_W-1:0]                      cnt_reg, cnt_next;
    logic                                  grant;
    logic [SEG_WORDS-1:0][SEG_WORD_W-1:0]  dbg_buf_reg;
    logic [SEG_WORDS-1:0][SEG_WORD_W-1:0]  cpu_act;
    logic [SEG_WORDS-1:0][SEG_WORD_W-1:0]  data_reg, data_next;
    logic                                  dbg_ack_reg;
`ifdef SEG_FRAME_ARB_READBACK_EN
    logic [SEG_WORDS-1:0][SEG_WORD_W-1:0]  shadow;
`endif

    seg_frame_buf u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .commit  (commit),
`ifdef SEG_FRAME_ARB_READBACK_EN
        .shadow  (shadow),
`endif
        .cpu_act (cpu_act)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_CPU;
            cnt_reg     <= '0;
            dbg_buf_reg <= '0;
            dbg_ack_reg <= 1'b0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            dbg_ack_reg <= grant;
            data_reg    <= data_next;
            if (grant) begin
                dbg_buf_reg <= dbg_frame;
            end
        end
    end

    // Counter is reloaded on every state entry, so it never wraps.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        grant      = 1'b0;
        case (state_reg)
            S_CPU: begin
                if (dbg_req) begin
                    grant      = 1'b1;
                    state_next = S_DBG;
                    cnt_next   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            S_DBG: begin
                if (cnt_reg == '0) begin
                    state_next = S_COOL;
                    cnt_next   = CNT_W'(COOL_CYCLES - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_COOL: begin
                if (cnt_reg == '0) begin
                    state_next = S_CPU;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = S_CPU;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        data_next = (state_reg == S_DBG) ? dbg_buf_reg : cpu_act;
        dbg_busy  = (state_reg == S_DBG);
    end

    assign dbg_ack = dbg_ack_reg;
    assign data_A  = data_reg[SEG_WORD_A];
    assign data_B  = data_reg[SEG_WORD_B];
    assign data_C  = data_reg[SEG_WORD_C];
    assign data_D  = data_reg[SEG_WORD_D];

`ifdef SEG_FRAME_ARB_READBACK_EN
    always_comb begin
        rd_data = '0;
        if (rd_addr[2] == 1'b0) begin
            rd_data = shadow[rd_addr[1:0]];
        end else if (rd_addr == 3'd4) begin
            rd_data = {14'b0, state_reg};
        end
    end
`endif

endmodule
